// File: rtl/hdmi_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdmi_rx_pkg: TMDS symbol constants, symbol kinds and video decode helper.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hdmi_rx_pkg;

  typedef enum logic [1:0] {
    KIND_CTRL  = 2'd0,
    KIND_GUARD = 2'd1,
    KIND_VIDEO = 2'd2,
    KIND_RSVD  = 2'd3
  } sym_kind_t;

  localparam logic [9:0] CTRL_TOKEN [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] VGUARD_CH0_2 = 10'b1011001100;
  localparam logic [9:0] VGUARD_CH1   = 10'b0100110011;
  localparam logic [9:0] DGUARD       = 10'b0100110011;

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [7:0] tmds_video_decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] r;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_channel_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmds_channel_decoder_if: raw symbol in, decoded TMDS channel stream out.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface tmds_channel_decoder_if;
  import hdmi_rx_pkg::*;

  logic [9:0] sym_in;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  sym_kind_t  kind;
  logic [3:0] terc4;
  logic       terc4_hit;

  modport master (
    input  sym_in,
    output bitslip, locked, de, ctrl, data, kind, terc4, terc4_hit
  );

  modport slave (
    output sym_in,
    input  bitslip, locked, de, ctrl, data, kind, terc4, terc4_hit
  );

endinterface
`default_nettype wire

// File: rtl/tmds_symbol_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmds_symbol_align: word-alignment FSM driving deserializer bitslip.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmds_symbol_align #(
  parameter int LOCK_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOSS_WINDOW   = 2**20
) (
  input  logic clk_hdmi,
  input  logic rst_hdmi_n,
  input  logic is_ctrl,
  output logic bitslip,
  output logic locked
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW);
  localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOW);

  localparam logic [RUN_W-1:0]  C_RUN_FULL  = RUN_W'(LOCK_RUN);
  localparam logic [RUN_W-1:0]  C_RUN_ONE   = RUN_W'(1);
  localparam logic [WIN_W-1:0]  C_WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [WIN_W-1:0]  C_WIN_ONE   = WIN_W'(1);
  localparam logic [SET_W-1:0]  C_SET_LAST  = SET_W'(SLIP_SETTLE - 1);
  localparam logic [SET_W-1:0]  C_SET_ONE   = SET_W'(1);
  localparam logic [LOSS_W-1:0] C_LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);
  localparam logic [LOSS_W-1:0] C_LOSS_ONE  = LOSS_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t            r_state;
  logic [RUN_W-1:0]  r_run;
  logic [WIN_W-1:0]  r_win;
  logic [SET_W-1:0]  r_settle;
  logic [LOSS_W-1:0] r_loss;
  logic [RUN_W-1:0]  w_run_next;
  logic              w_run_done;

  // Run counter saturates, so a long blanking period keeps re-completing the run.
  always_comb begin
    w_run_next = '0;
    if (is_ctrl) begin
      w_run_next = (r_run == C_RUN_FULL) ? r_run : r_run + C_RUN_ONE;
    end
    w_run_done = (w_run_next == C_RUN_FULL);
  end

  always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
    if (!rst_hdmi_n) begin
      r_state  <= ST_SEARCH;
      r_run    <= '0;
      r_win    <= '0;
      r_settle <= '0;
      r_loss   <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          r_run <= w_run_next;
          if (w_run_done) begin
            r_state <= ST_LOCKED;
            locked  <= 1'b1;
            r_loss  <= '0;
          end else if (r_win == C_WIN_LAST) begin
            r_state <= ST_SLIP;
            bitslip <= 1'b1;
          end else begin
            r_win <= r_win + C_WIN_ONE;
          end
        end
        ST_SLIP: begin
          r_state  <= ST_SETTLE;
          r_settle <= '0;
        end
        ST_SETTLE: begin
          if (r_settle == C_SET_LAST) begin
            r_state <= ST_SEARCH;
            r_run   <= '0;
            r_win   <= '0;
          end else begin
            r_settle <= r_settle + C_SET_ONE;
          end
        end
        ST_LOCKED: begin
          r_run <= w_run_next;
          if (w_run_done) begin
            r_loss <= '0;
          end else if (r_loss == C_LOSS_LAST) begin
            r_state <= ST_SEARCH;
            locked  <= 1'b0;
            r_run   <= '0;
            r_win   <= '0;
          end else begin
            r_loss <= r_loss + C_LOSS_ONE;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmds_channel_decoder: aligns, classifies and decodes one TMDS channel.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmds_channel_decoder
  import hdmi_rx_pkg::*;
#(
  parameter int CHANNEL       = 0,
  parameter int LOCK_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOSS_WINDOW   = 2**20
) (
  input  logic                          clk_hdmi,
  input  logic                          rst_hdmi_n,
  tmds_channel_decoder_if.master        bus
);

  localparam logic [9:0] C_VGUARD = (CHANNEL == 1) ? VGUARD_CH1 : VGUARD_CH0_2;

  logic [9:0] r_sym;
  logic       r_de;
  logic [1:0] r_ctrl;
  logic [7:0] r_data;
  sym_kind_t  r_kind;
  logic [3:0] r_terc4;
  logic       r_terc4_hit;

  logic       w_is_ctrl;
  logic [1:0] w_ctrl_val;
  logic       w_is_guard;
  logic       w_hit;
  logic [3:0] w_nib;
  logic       w_bitslip;
  logic       w_locked;

  always_comb begin
    w_is_ctrl  = 1'b0;
    w_ctrl_val = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (r_sym == CTRL_TOKEN[i]) begin
        w_is_ctrl  = 1'b1;
        w_ctrl_val = 2'(i);
      end
    end
    w_hit = 1'b0;
    w_nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (r_sym == TERC4_CODE[i]) begin
        w_hit = 1'b1;
        w_nib = 4'(i);
      end
    end
    // The data-island guard only aliases a guard on channels 1 and 2.
    w_is_guard = (r_sym == C_VGUARD) || ((CHANNEL != 0) && (r_sym == DGUARD));
  end

  tmds_symbol_align #(
    .LOCK_RUN      (LOCK_RUN),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_SETTLE   (SLIP_SETTLE),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) u_align (
    .clk_hdmi   (clk_hdmi),
    .rst_hdmi_n (rst_hdmi_n),
    .is_ctrl    (w_is_ctrl),
    .bitslip    (w_bitslip),
    .locked     (w_locked)
  );

  always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
    if (!rst_hdmi_n) begin
      r_sym       <= '0;
      r_de        <= 1'b0;
      r_ctrl      <= 2'b00;
      r_data      <= 8'h00;
      r_kind      <= KIND_CTRL;
      r_terc4     <= 4'h0;
      r_terc4_hit <= 1'b0;
    end else begin
      r_sym       <= bus.sym_in;
      r_terc4     <= w_nib;
      r_terc4_hit <= w_locked && w_hit;
      r_de        <= w_locked && !w_is_ctrl && !w_is_guard;
      r_data      <= (w_locked && !w_is_ctrl && !w_is_guard) ? tmds_video_decode(r_sym) : 8'h00;
      if (w_is_ctrl) begin
        r_kind <= KIND_CTRL;
      end else if (w_is_guard) begin
        r_kind <= KIND_GUARD;
      end else begin
        r_kind <= KIND_VIDEO;
      end
      if (w_locked && w_is_ctrl) begin
        r_ctrl <= w_ctrl_val;
      end
    end
  end

  assign bus.bitslip   = w_bitslip;
  assign bus.locked    = w_locked;
  assign bus.de        = r_de;
  assign bus.ctrl      = r_ctrl;
  assign bus.data      = r_data;
  assign bus.kind      = r_kind;
  assign bus.terc4     = r_terc4;
  assign bus.terc4_hit = r_terc4_hit;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tmds_channel_decoder: self-checking bench with a TMDS encoder model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tmds_channel_decoder;

  localparam int CHANNEL       = 0;
  localparam int LOCK_RUN      = 8;
  localparam int SEARCH_WINDOW = 64;
  localparam int SLIP_SETTLE   = 4;
  localparam int LOSS_WINDOW   = 512;

  localparam logic [1:0] K_CTRL  = 2'd0;
  localparam logic [1:0] K_GUARD = 2'd1;
  localparam logic [1:0] K_VIDEO = 2'd2;
  localparam logic [9:0] TB_GUARD = 10'b1011001100;

  logic clk_hdmi   = 1'b0;
  logic rst_hdmi_n = 1'b0;
  always #5 clk_hdmi = ~clk_hdmi;

  tmds_channel_decoder_if bus ();

  tmds_channel_decoder #(
    .CHANNEL       (CHANNEL),
    .LOCK_RUN      (LOCK_RUN),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_SETTLE   (SLIP_SETTLE),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) dut (
    .clk_hdmi   (clk_hdmi),
    .rst_hdmi_n (rst_hdmi_n),
    .bus        (bus.master)
  );

  logic [9:0] tb_ctrl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] tb_terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct packed {
    logic       chk;
    logic       de;
    logic       cd;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [1:0] kind;
    logic       hit;
    logic [3:0] t4;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t cur_exp = '0;
  exp_t e1 = '0;
  exp_t e2 = '0;
  logic [1:0] model_ctrl = 2'b00;
  int   enc_disp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {46'd0, bus.bitslip, bus.locked, bus.de, bus.ctrl, bus.data, 2'(bus.kind), bus.terc4, bus.terc4_hit};
  endfunction

  function automatic logic [9:0] rotr(input logic [9:0] w, input int off);
    logic [19:0] dd;
    dd = {w, w};
    return dd[off +: 10];
  endfunction

  // DVI transmit encoder with running disparity.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    int n1, n1q, n0q;
    logic [8:0] qm;
    logic [9:0] q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      q[9] = ~qm[8];
      q[8] = qm[8];
      q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      if (qm[8] == 1'b0) enc_disp += n0q - n1q;
      else               enc_disp += n1q - n0q;
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      q[9] = 1'b1;
      q[8] = qm[8];
      q[7:0] = ~qm[7:0];
      enc_disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q[9] = 1'b0;
      q[8] = qm[8];
      q[7:0] = qm[7:0];
      enc_disp += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return q;
  endfunction

  function automatic exp_t expect_sym(input logic [9:0] s, input logic cd, input logic [7:0] b);
    exp_t e;
    e      = '0;
    e.chk  = 1'b1;
    e.kind = K_VIDEO;
    e.de   = 1'b1;
    e.cd   = cd;
    e.data = b;
    for (int i = 0; i < 16; i++) begin
      if (s == tb_terc4[i]) begin
        e.hit = 1'b1;
        e.t4  = 4'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (s == tb_ctrl[i]) begin
        e.kind     = K_CTRL;
        e.de       = 1'b0;
        model_ctrl = 2'(i);
      end
    end
    if (s == TB_GUARD) begin
      e.kind = K_GUARD;
      e.de   = 1'b0;
    end
    e.ctrl = model_ctrl;
    return e;
  endfunction

  task automatic drive(input logic [9:0] s, input logic cd, input logic [7:0] b, input logic chk);
    exp_t e;
    @(posedge clk_hdmi);
    #1;
    e = expect_sym(s, cd, b);
    e.chk = chk;
    bus.sym_in = s;
    cur_exp = e;
  endtask

  // Outputs reflect the symbol driven two edges earlier.
  initial begin
    forever begin
      @(posedge clk_hdmi);
      e2 = e1;
      e1 = cur_exp;
      @(negedge clk_hdmi);
      if (e2.chk && rst_hdmi_n) begin
        check("locked_hold", {63'd0, bus.locked}, 64'd1);
        check("stream",
              {45'd0, bus.de, (e2.de && e2.cd) ? bus.data : 8'h00, bus.ctrl, 2'(bus.kind),
               bus.terc4_hit, e2.hit ? bus.terc4 : 4'h0},
              {45'd0, e2.de, (e2.de && e2.cd) ? e2.data : 8'h00, e2.ctrl, e2.kind,
               e2.hit, e2.hit ? e2.t4 : 4'h0});
      end
    end
  end

  initial begin
    int   off, pulses, quiet, min_gap, first_slip, lc;
    logic got;
    bus.sym_in = '0;

    // Reset with random symbols on the input
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_hdmi);
      #1 bus.sym_in = 10'($urandom);
    end
    @(negedge clk_hdmi);
    check("reset_vals", out_vec(), 64'd0);

    // Lock acquisition through a deserializer rotated by 3 bits
    off = 3; pulses = 0; quiet = 0; min_gap = 1 << 30; first_slip = -1; got = 1'b0;
    @(posedge clk_hdmi);
    #1;
    rst_hdmi_n = 1'b1;
    bus.sym_in = rotr(tb_ctrl[0], off);
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk_hdmi);
      if (bus.bitslip) begin
        if (first_slip < 0) first_slip = c;
        if (pulses > 0 && quiet < min_gap) min_gap = quiet;
        pulses++;
        quiet = 0;
        off = (off == 0) ? 9 : off - 1;
      end else begin
        quiet++;
      end
      if (bus.locked) begin
        got = 1'b1;
        if (quiet < min_gap) min_gap = quiet;
      end else begin
        @(posedge clk_hdmi);
        #1 bus.sym_in = rotr(tb_ctrl[0], off);
      end
    end
    check("lock_acquired", {63'd0, got}, 64'd1);
    check("no_early_slip", {63'd0, first_slip >= 10}, 64'd1);
    check("slip_count", 64'(pulses), 64'd3);
    check("slip_gap", {63'd0, min_gap >= SLIP_SETTLE}, 64'd1);
    check("ctrl_after_lock", {62'd0, bus.ctrl}, 64'd0);

    // Video decode, hand-computed literals first
    for (int i = 0; i < 4; i++) drive(tb_ctrl[0], 1'b0, 8'h00, 1'b1);
    drive(10'h100, 1'b1, 8'h00, 1'b1);
    drive(10'h2FF, 1'b1, 8'hFE, 1'b1);
    @(posedge clk_hdmi);
    @(posedge clk_hdmi);
    @(negedge clk_hdmi);
    check("lit_2ff_data", {56'd0, bus.data}, 64'hFE);

    enc_disp = 0;
    check("enc_pin_00", {54'd0, tmds_enc(8'h00)}, 64'h100);
    enc_disp = 0;
    check("enc_pin_ff", {54'd0, tmds_enc(8'hFF)}, 64'h200);
    enc_disp = 0;
    for (int b = 0; b < 256; b++) begin
      logic [9:0] s;
      s = tmds_enc(8'(b));
      drive(s, 1'b1, 8'(b), 1'b1);
    end

    // Control tokens and guard
    for (int i = 0; i < LOCK_RUN; i++) drive(tb_ctrl[0], 1'b0, 8'h00, 1'b1);
    for (int t = 1; t < 4; t++) begin
      drive(tb_ctrl[t], 1'b0, 8'h00, 1'b1);
      drive(tb_ctrl[t], 1'b0, 8'h00, 1'b1);
    end
    @(posedge clk_hdmi);
    @(posedge clk_hdmi);
    @(negedge clk_hdmi);
    check("lit_ctrl11", {62'd0, bus.ctrl}, 64'd3);
    for (int i = 0; i < LOCK_RUN; i++) drive(tb_ctrl[3], 1'b0, 8'h00, 1'b1);
    drive(TB_GUARD, 1'b0, 8'h00, 1'b1);
    drive(TB_GUARD, 1'b0, 8'h00, 1'b1);
    @(posedge clk_hdmi);
    @(posedge clk_hdmi);
    @(negedge clk_hdmi);
    check("lit_guard_kind", {61'd0, 2'(bus.kind), bus.de}, {61'd0, K_GUARD, 1'b0});

    // TERC4 table, then refresh the lock run
    for (int i = 0; i < 16; i++) drive(tb_terc4[i], 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < LOCK_RUN; i++) drive(tb_ctrl[3], 1'b0, 8'h00, 1'b1);

    // Loss of lock under continuous video
    got = 1'b0; lc = 0;
    for (int c = 0; c < LOSS_WINDOW + 100 && !got; c++) begin
      drive(10'h100, 1'b0, 8'h00, 1'b0);
      @(negedge clk_hdmi);
      lc++;
      if (!bus.locked) got = 1'b1;
    end
    check("loss_drop", {63'd0, got}, 64'd1);
    check("loss_time", {63'd0, (lc >= LOSS_WINDOW - 8) && (lc <= LOSS_WINDOW + 8)}, 64'd1);

    got = 1'b0;
    for (int c = 0; c < SEARCH_WINDOW + 20 && !got; c++) begin
      drive(10'h100, 1'b0, 8'h00, 1'b0);
      @(negedge clk_hdmi);
      if (bus.bitslip) got = 1'b1;
    end
    check("slip_resumes", {63'd0, got}, 64'd1);

    // Asynchronous reset while settling after the slip
    @(posedge clk_hdmi);
    #2 rst_hdmi_n = 1'b0;
    #1;
    check("reset_mid_settle", out_vec(), 64'd0);
    repeat (3) @(posedge clk_hdmi);
    #1 rst_hdmi_n = 1'b1;
    repeat (3) @(negedge clk_hdmi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
